// File: rtl/rv32_pkg.sv
// Shared RV32I encodings for the execute stage: ALU op codes, major opcodes,
// branch conditions and the decode/entry records passed between blocks.
package rv32_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} b_sel_e;

  typedef struct packed {
    logic [3:0] alu_op;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    logic       illegal;
    logic       reg_we;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
  } dec_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [31:0] redirect_pc;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        illegal;
  } entry_t;

  // alt selects SUB over ADD and SRA over SRL; callers mask it per format.
  function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Decode-side and memory/writeback-side buses of the execute stage.
// master = surrounding pipeline, slave = execute stage.
interface alu_exec_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_we;
  logic        out_mem_read;
  logic        out_mem_write;
  logic [2:0]  out_funct3;
  logic        out_illegal;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output in_valid, opcode, funct3, funct7_5, pc, rs1_data, rs2_data, imm, rd,
           flush, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_we,
           out_mem_read, out_mem_write, out_funct3, out_illegal, redirect, redirect_pc
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7_5, pc, rs1_data, rs2_data, imm, rd,
           flush, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_we,
           out_mem_read, out_mem_write, out_funct3, out_illegal, redirect, redirect_pc
  );
endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU with comparison flags used for branch resolution.
module alu
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      op_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            lt_o,
  output logic            ltu_o
);

  always_comb begin
    lt_o  = $signed(a_i) < $signed(b_i);
    ltu_o = a_i < b_i;
  end

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_SLL:   result_o = a_i << b_i[4:0];
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, lt_o};
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, ltu_o};
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SRL:   result_o = a_i >> b_i[4:0];
      ALU_SRA:   result_o = $signed(a_i) >>> b_i[4:0];
      ALU_OR:    result_o = a_i | b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_LUI:   result_o = b_i;
      ALU_AUIPC: result_o = a_i + b_i;
      default:   result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_op_decode.sv
// Maps opcode/funct3/funct7_5 to ALU op, operand selects and instruction class.
module alu_op_decode
  import rv32_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.alu_op = ALU_ADD;
    dec_o.a_sel  = A_RS1;
    dec_o.b_sel  = B_RS2;
    case (opcode_i)
      OPC_OP: begin
        dec_o.alu_op = alu_op_from_funct3(funct3_i, funct7_5_i);
        dec_o.reg_we = 1'b1;
      end
      OPC_OPIMM: begin
        // Only SRAI looks at funct7_5; ADDI must never become a subtract.
        dec_o.alu_op = alu_op_from_funct3(funct3_i, funct7_5_i && (funct3_i == 3'b101));
        dec_o.b_sel  = B_IMM;
        dec_o.reg_we = 1'b1;
      end
      OPC_LUI: begin
        dec_o.alu_op = ALU_LUI;
        dec_o.a_sel  = A_ZERO;
        dec_o.b_sel  = B_IMM;
        dec_o.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec_o.alu_op = ALU_AUIPC;
        dec_o.a_sel  = A_PC;
        dec_o.b_sel  = B_IMM;
        dec_o.reg_we = 1'b1;
      end
      OPC_LOAD: begin
        dec_o.b_sel    = B_IMM;
        dec_o.reg_we   = 1'b1;
        dec_o.mem_read = 1'b1;
      end
      OPC_STORE: begin
        dec_o.b_sel     = B_IMM;
        dec_o.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec_o.alu_op = ALU_SUB;
        if (funct3_i[2:1] == 2'b01) dec_o.illegal = 1'b1;
        else                        dec_o.branch  = 1'b1;
      end
      OPC_JAL: begin
        dec_o.a_sel  = A_PC;
        dec_o.b_sel  = B_FOUR;
        dec_o.reg_we = 1'b1;
        dec_o.jump   = 1'b1;
      end
      OPC_JALR: begin
        dec_o.a_sel  = A_PC;
        dec_o.b_sel  = B_FOUR;
        dec_o.reg_we = 1'b1;
        dec_o.jump   = 1'b1;
        dec_o.jalr   = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// RV32I execute stage: operand select, ALU, branch/jump resolution and a
// one-entry output register toward memory/writeback.
module alu_exec_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_stage_if.slave  bus
);

  dec_t            dec;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            alu_zero;
  logic            alu_lt;
  logic            alu_ltu;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic            taken;
  logic            redirect_new;
  logic            in_ready;
  logic            accept;
  entry_t          entry_new;
  entry_t          entry_d, entry_q;
  logic            valid_d, valid_q;
  logic            redirect_d, redirect_q;

  alu_op_decode u_dec (
    .opcode_i   (bus.opcode),
    .funct3_i   (bus.funct3),
    .funct7_5_i (bus.funct7_5),
    .dec_o      (dec)
  );

  always_comb begin
    case (dec.a_sel)
      A_PC:    op_a = bus.pc;
      A_ZERO:  op_a = '0;
      default: op_a = bus.rs1_data;
    endcase
    case (dec.b_sel)
      B_IMM:   op_b = bus.imm;
      B_FOUR:  op_b = XLEN'(4);
      default: op_b = bus.rs2_data;
    endcase
  end

  alu #(.XLEN(XLEN)) u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .op_i     (dec.alu_op),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .lt_o     (alu_lt),
    .ltu_o    (alu_ltu)
  );

  // Target adders stay off the ALU so JAL/JALR can use it for the link value.
  assign br_target = bus.pc + bus.imm;
  assign jalr_sum  = bus.rs1_data + bus.imm;

  always_comb begin
    taken = 1'b0;
    case (br_funct3_e'(bus.funct3))
      BR_BEQ:  taken = alu_zero;
      BR_BNE:  taken = !alu_zero;
      BR_BLT:  taken = alu_lt;
      BR_BGE:  taken = !alu_lt;
      BR_BLTU: taken = alu_ltu;
      BR_BGEU: taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  assign redirect_new = (dec.branch && taken) || dec.jump;
  assign in_ready     = !valid_q || bus.out_ready || bus.flush;
  assign accept       = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    entry_new             = '0;
    entry_new.result      = alu_res;
    entry_new.store_data  = bus.rs2_data;
    entry_new.redirect_pc = dec.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;
    entry_new.rd          = bus.rd;
    entry_new.reg_we      = dec.reg_we && (bus.rd != 5'd0);
    entry_new.mem_read    = dec.mem_read;
    entry_new.mem_write   = dec.mem_write;
    entry_new.funct3      = bus.funct3;
    entry_new.illegal     = dec.illegal;
  end

  // redirect is a pulse: it drops after one cycle regardless of stalls.
  always_comb begin
    entry_d    = entry_q;
    valid_d    = valid_q && !bus.out_ready;
    redirect_d = 1'b0;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      entry_d    = entry_new;
      valid_d    = 1'b1;
      redirect_d = redirect_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q    <= '0;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = valid_q;
  assign bus.out_result     = entry_q.result;
  assign bus.out_store_data = entry_q.store_data;
  assign bus.out_rd         = entry_q.rd;
  assign bus.out_reg_we     = entry_q.reg_we;
  assign bus.out_mem_read   = entry_q.mem_read;
  assign bus.out_mem_write  = entry_q.mem_write;
  assign bus.out_funct3     = entry_q.funct3;
  assign bus.out_illegal    = entry_q.illegal;
  assign bus.redirect       = redirect_q;
  assign bus.redirect_pc    = entry_q.redirect_pc;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
RV32I execute stage sitting directly upstream of the combinational `alu`.
- Takes decoded instructions from decode under a valid/ready handshake.
- Selects ALU operands and derives `alu_op`.
- Resolves branches and jumps, and registers the result for the memory/writeback stage in a one-entry output register.
- Contains the only `alu` instance in the core.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7_5  in  1  instruction[30]
- pc  in  32  instruction PC
- rs1_data  in  32  register operand 1
- rs2_data  in  32  register operand 2
- imm  in  32  sign-extended immediate, already formatted per instruction type
- rd  in  5  destination register
- flush  in  1  discard the held entry and any input this cycle
- out_valid  out  1  output register holds an entry
- out_ready  in  1  downstream accepts
- out_result  out  32  ALU result, link address, or memory address
- out_store_data  out  32  rs2_data, passed through for stores
- out_rd  out  5  destination register
- out_reg_we  out  1  write rd; forced 0 when rd==0
- out_mem_read  out  1  load
- out_mem_write  out  1  store
- out_funct3  out  3  passed through for load/store sizing
- out_illegal  out  1  unrecognised opcode
- redirect  out  1  branch taken or jump
- redirect_pc  out  32  target address

Behaviour:
- Reset: all out_* = 0, redirect = 0, redirect_pc = 0.
- in_ready = !out_valid || out_ready; in_ready is also forced 1 while flush=1.
- Accept: in_valid && in_ready && !flush. The entry is registered on that edge, so latency is one cycle.
- Hold: out_valid && !out_ready keeps every output stable.
- Drain: out_valid && out_ready && no accept clears out_valid on the next edge.

Operand and ALU-op selection (ALU codes are fixed: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, LUI 10, AUIPC 11):
- OP (0110011): a=rs1, b=rs2. funct3 selects the op. funct7_5 selects SUB over ADD and SRA over SRL.
- OP-IMM (0010011): a=rs1, b=imm. funct7_5 is honoured only for shift-right (SRAI); ADDI never subtracts.
- LUI (0110111): op LUI, b=imm.
- AUIPC (0010111): op AUIPC, a=pc, b=imm.
- LOAD (0000011) / STORE (0100011): op ADD, a=rs1, b=imm. Loads set out_reg_we; stores set out_mem_write and clear out_reg_we.
- BRANCH (1100011): op SUB, a=rs1, b=rs2. out_reg_we=0.
  - Taken condition by funct3: BEQ zero; BNE !zero; BLT less_than; BGE !less_than; BLTU less_than_u; BGEU !less_than_u.
  - funct3 010/011 is treated as illegal.
  - redirect_pc = pc+imm.
- JAL (1101111): out_result = pc+4, redirect=1, redirect_pc = pc+imm.
- JALR (1100111): out_result = pc+4, redirect=1, redirect_pc = (rs1+imm) & ~1.
- Any other opcode: out_illegal=1; out_reg_we, out_mem_* and redirect are all 0.

Arithmetic:
- All adds wrap modulo 2^32.
- The two target adders are separate from the ALU.

Redirect timing:
- redirect and redirect_pc are registered with the entry.
- redirect is a one-cycle pulse, asserted the cycle after acceptance, even if the entry stalls.

Flush:
- Clears out_valid and redirect on the next edge.
- Flush has priority over a simultaneous accept and over hold.

Reset mid-operation:
- Asynchronously drops out_valid and redirect immediately.

Decomposition:
- Package `rv32_pkg` holds:
  - ALU op localparams (ALU_ADD..ALU_AUIPC);
  - opcode localparams (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR);
  - a branch funct3 enum.
- One natural sub-module: `alu_op_decode`, a combinational map from opcode/funct3/funct7_5 to alu_op, operand selects and illegal.
- The existing `alu` is instantiated unchanged.

Test Plan:
1. OP SUB: rs1=8, rs2=3, funct7_5=1, rd=5 -> next cycle out_valid=1, out_result=5, out_reg_we=1, out_rd=5, redirect=0.
2. OP-IMM SRAI: rs1=F0000000, imm=404 (imm[10] set, shamt 4), funct7_5=1 -> out_result=FF000000; the same with funct7_5=0 -> 0F000000.
3. BLT: rs1=FFFFFFFF, rs2=1, pc=100, imm=20 -> redirect=1 for one cycle, redirect_pc=120, out_reg_we=0. BLTU with the same operands -> redirect=0.
4. JALR: pc=200, rs1=1001, imm=4, rd=1 -> out_result=204, redirect_pc=1004, out_reg_we=1. The same with rd=0 -> out_reg_we=0.
5. Back-pressure: out_ready=0 with a held entry -> in_ready=0 and outputs stable for 3 cycles. Raising out_ready accepts the next input in the same cycle, and no entry is lost or duplicated.
6. Flush asserted with in_valid=1 while an entry is held -> out_valid=0 next cycle, input dropped. rst_n low mid-stall -> all outputs 0 immediately.
